// File: rtl/regfile_operand_fetch.sv
// Operand fetch / write-back initiator for a 3-read, 1-write register file.
// Runs one ARM data-processing instruction at a time: decode, read, issue, write back.
module regfile_operand_fetch #(
  parameter int DATA_W    = 32,
  parameter int PC_OFFSET = 8
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic              Inst_Valid,
  input  logic [31:0]       Inst,
  input  logic [DATA_W-1:0] PC_In,
  output logic              Inst_Ready,
  output logic [3:0]        R_Addr_A,
  output logic [3:0]        R_Addr_B,
  output logic [3:0]        R_Addr_C,
  input  logic [DATA_W-1:0] R_Data_A,
  input  logic [DATA_W-1:0] R_Data_B,
  input  logic [DATA_W-1:0] R_Data_C,
  output logic [DATA_W-1:0] Op_A,
  output logic [DATA_W-1:0] Op_B,
  output logic [DATA_W-1:0] Op_C,
  output logic              Op_Valid,
  input  logic              Op_Ready,
  input  logic              Res_Valid,
  input  logic [DATA_W-1:0] Res_Data,
  input  logic              Res_Write,
  output logic              Res_Ready,
  output logic [3:0]        W_Addr,
  output logic [DATA_W-1:0] W_Data,
  output logic              Write_Reg,
  output logic              PC_Load,
  output logic [DATA_W-1:0] PC_Data
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; the offering side holds its payload stable until that edge.

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_ISSUE,
    S_WAIT_RES,
    S_WRITE
  } state_t;

  localparam logic [3:0] PC_REG = 4'hF;

  state_t            state_q, state_d;
  logic [3:0]        rn_q, rn_d, rd_q, rd_d, rs_q, rs_d, rm_q, rm_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d, op_c_q, op_c_d;
  logic [3:0]        w_addr_q, w_addr_d;
  logic [DATA_W-1:0] w_data_q, w_data_d;
  logic              pc_load_q, pc_load_d;
  logic [DATA_W-1:0] pc_data_q, pc_data_d;
  logic [DATA_W-1:0] pc_read;

  // Only the register fields are decoded; the rest of the word is ignored.
  logic unused_inst_bits;
  assign unused_inst_bits = ^{Inst[31:20], Inst[7:4]};

  // R15 reads as the pipeline-visible PC, wrapping at DATA_W bits.
  assign pc_read = pc_q + DATA_W'(PC_OFFSET);

  always_comb begin
    state_d   = state_q;
    rn_d      = rn_q;
    rd_d      = rd_q;
    rs_d      = rs_q;
    rm_d      = rm_q;
    pc_d      = pc_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    op_c_d    = op_c_q;
    w_addr_d  = w_addr_q;
    w_data_d  = w_data_q;
    pc_load_d = 1'b0;
    pc_data_d = pc_data_q;
    case (state_q)
      S_IDLE: begin
        if (Inst_Valid) begin
          rn_d    = Inst[19:16];
          rd_d    = Inst[15:12];
          rs_d    = Inst[11:8];
          rm_d    = Inst[3:0];
          pc_d    = PC_In;
          state_d = S_READ;
        end
      end
      S_READ: begin
        op_a_d  = (rn_q == PC_REG) ? pc_read : R_Data_A;
        op_b_d  = (rm_q == PC_REG) ? pc_read : R_Data_B;
        op_c_d  = (rs_q == PC_REG) ? pc_read : R_Data_C;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (Op_Ready) state_d = S_WAIT_RES;
      end
      S_WAIT_RES: begin
        if (Res_Valid) begin
          if (!Res_Write) begin
            state_d = S_IDLE;
          end else if (rd_q == PC_REG) begin
            pc_load_d = 1'b1;
            pc_data_d = Res_Data;
            state_d   = S_IDLE;
          end else begin
            w_addr_d = rd_q;
            w_data_d = Res_Data;
            state_d  = S_WRITE;
          end
        end
      end
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!Rst) begin
      state_q   <= S_IDLE;
      rn_q      <= '0;
      rd_q      <= '0;
      rs_q      <= '0;
      rm_q      <= '0;
      pc_q      <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      op_c_q    <= '0;
      w_addr_q  <= '0;
      w_data_q  <= '0;
      pc_load_q <= 1'b0;
      pc_data_q <= '0;
    end else begin
      state_q   <= state_d;
      rn_q      <= rn_d;
      rd_q      <= rd_d;
      rs_q      <= rs_d;
      rm_q      <= rm_d;
      pc_q      <= pc_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      op_c_q    <= op_c_d;
      w_addr_q  <= w_addr_d;
      w_data_q  <= w_data_d;
      pc_load_q <= pc_load_d;
      pc_data_q <= pc_data_d;
    end
  end

  assign Inst_Ready = (state_q == S_IDLE);
  assign Op_Valid   = (state_q == S_ISSUE);
  assign Res_Ready  = (state_q == S_WAIT_RES);
  assign Write_Reg  = (state_q == S_WRITE);
  assign R_Addr_A   = rn_q;
  assign R_Addr_B   = rm_q;
  assign R_Addr_C   = rs_q;
  assign Op_A       = op_a_q;
  assign Op_B       = op_b_q;
  assign Op_C       = op_c_q;
  assign W_Addr     = w_addr_q;
  assign W_Data     = w_data_q;
  assign PC_Load    = pc_load_q;
  assign PC_Data    = pc_data_q;

endmodule
